// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared definitions for the matrix operation sequencer:
//               operation codes, sequencer state encoding, dimension width,
//               default maximum dimension and small address/check helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    // Width of a row/column count or index.
    localparam int DIM_W       = 3;
    // Largest supported row or column count.
    localparam int MAX_DIM_C   = 5;
    // Width wide enough for r*C+c with every term at its 3-bit maximum.
    localparam int FLAT_ADDR_W = 2 * DIM_W;

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_TRANSPOSE = 4'd2;
    localparam logic [3:0] OP_SCALAR    = 4'd3;
    localparam logic [3:0] OP_MUL       = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Row-major element address: element (r,c) of a matrix with `cols` columns.
    function automatic logic [FLAT_ADDR_W-1:0] elem_addr(
        input logic [DIM_W-1:0] r,
        input logic [DIM_W-1:0] c,
        input logic [DIM_W-1:0] cols
    );
        return FLAT_ADDR_W'(r) * FLAT_ADDR_W'(cols) + FLAT_ADDR_W'(c);
    endfunction

    // A dimension is unusable when it is zero or exceeds the supported maximum.
    function automatic logic dim_bad(
        input logic [DIM_W-1:0] d,
        input int unsigned      max_dim
    );
        return (d == '0) || (32'(d) > max_dim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_op_sequencer_counter.sv
`default_nettype none
// ============================================================================
// Module      : mat_index_counter
// Description : Nested i/j/k loop counters with programmable limits. k is the
//               innermost loop, then j, then i. Each counter wraps to 0 when
//               it reaches its limit-1 and carries into the next outer one.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_clear       - synchronous return of all counters to 0
//               i_en          - advance by one iteration
//               i_lim_i/j/k   - loop limits (must be >= 1 while enabled)
//               o_i/o_j/o_k   - current indices
//               o_last_k      - k is at its final value
//               o_last_all    - current iteration is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module mat_index_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [DIM_W-1:0] i_lim_i,
    input  logic [DIM_W-1:0] i_lim_j,
    input  logic [DIM_W-1:0] i_lim_k,
    output logic [DIM_W-1:0] o_i,
    output logic [DIM_W-1:0] o_j,
    output logic [DIM_W-1:0] o_k,
    output logic             o_last_k,
    output logic             o_last_all
);

    logic [DIM_W-1:0] r_i;
    logic [DIM_W-1:0] r_j;
    logic [DIM_W-1:0] r_k;
    logic             w_last_i;
    logic             w_last_j;
    logic             w_last_k;

    assign w_last_i   = (r_i == i_lim_i - DIM_W'(1));
    assign w_last_j   = (r_j == i_lim_j - DIM_W'(1));
    assign w_last_k   = (r_k == i_lim_k - DIM_W'(1));

    assign o_i        = r_i;
    assign o_j        = r_j;
    assign o_k        = r_k;
    assign o_last_k   = w_last_k;
    assign o_last_all = w_last_k & w_last_j & w_last_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_clear) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_en) begin
            if (w_last_k) begin
                r_k <= '0;
                if (w_last_j) begin
                    r_j <= '0;
                    r_i <= w_last_i ? '0 : r_i + DIM_W'(1);
                end else begin
                    r_j <= r_j + DIM_W'(1);
                end
            end else begin
                r_k <= r_k + DIM_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_op_sequencer
// Description : Runs one matrix operation (ADD, TRANSPOSE, SCALAR, MUL) per
//               rising edge of i_start. Operands are read element by element
//               from synchronous storage (data one cycle after address), the
//               result is computed in a two-stage pipeline and written
//               row-major into the result buffer.
// Ports       : clk, rst                 - clock, asynchronous active-high reset
//               i_start, i_abort         - request level / synchronous cancel
//               i_op_type, i_*_rows/cols - operation and dimensions
//               i_scalar                 - scalar multiplier
//               o_a_addr/o_b_addr        - operand read addresses
//               i_a_data/i_b_data        - operand read data
//               o_res_we/addr/data       - result write port
//               o_res_rows/o_res_cols    - result dimensions after completion
//               o_busy, o_calc_done, o_error_out - status to controller
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_op_sequencer
    import matrix_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20,
    parameter int MAX_DIM = MAX_DIM_C,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [3:0]        i_op_type,
    input  logic [DIM_W-1:0]  i_a_rows,
    input  logic [DIM_W-1:0]  i_a_cols,
    input  logic [DIM_W-1:0]  i_b_rows,
    input  logic [DIM_W-1:0]  i_b_cols,
    input  logic [DATA_W-1:0] i_scalar,
    output logic [ADDR_W-1:0] o_a_addr,
    output logic [ADDR_W-1:0] o_b_addr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_res_we,
    output logic [ADDR_W-1:0] o_res_addr,
    output logic [ACC_W-1:0]  o_res_data,
    output logic [DIM_W-1:0]  o_res_rows,
    output logic [DIM_W-1:0]  o_res_cols,
    output logic              o_busy,
    output logic              o_calc_done,
    output logic              o_error_out
);

    state_e            r_state;
    logic              r_start;
    logic [3:0]        r_op;
    logic [DIM_W-1:0]  r_a_rows;
    logic [DIM_W-1:0]  r_a_cols;
    logic [DIM_W-1:0]  r_b_rows;
    logic [DIM_W-1:0]  r_b_cols;
    logic [DATA_W-1:0] r_scalar;
    logic              r_drain_cnt;

    logic              w_start_edge;
    logic              w_kill;
    logic              w_req_bad;
    logic [DIM_W-1:0]  w_lim_j;
    logic [DIM_W-1:0]  w_lim_k;
    logic [DIM_W-1:0]  w_i;
    logic [DIM_W-1:0]  w_j;
    logic [DIM_W-1:0]  w_k;
    logic              w_last_k;
    logic              w_last_all;
    logic [DIM_W-1:0]  w_res_rows;
    logic [DIM_W-1:0]  w_res_cols;
    logic [FLAT_ADDR_W-1:0] w_a_flat;
    logic [FLAT_ADDR_W-1:0] w_b_flat;
    logic [FLAT_ADDR_W-1:0] w_res_flat;

    // Pipeline stage 1: describes the operand pair arriving this cycle.
    logic              r_p1_valid;
    logic              r_p1_first;
    logic              r_p1_last;
    logic [ADDR_W-1:0] r_p1_addr;
    logic [ACC_W-1:0]  r_acc;

    logic [ACC_W-1:0]  w_a_ext;
    logic [ACC_W-1:0]  w_b_ext;
    logic [ACC_W-1:0]  w_s_ext;
    logic [ACC_W-1:0]  w_elem;

    assign w_start_edge = i_start & ~r_start;
    assign w_kill       = i_abort && ((r_state == ST_CHECK) ||
                                      (r_state == ST_RUN)   ||
                                      (r_state == ST_DRAIN));

    // ------------------------------------------------------------------
    // Request validation against the latched request
    // ------------------------------------------------------------------
    always_comb begin
        w_req_bad = 1'b0;
        case (r_op)
            OP_ADD: w_req_bad = dim_bad(r_a_rows, MAX_DIM) | dim_bad(r_a_cols, MAX_DIM) |
                                dim_bad(r_b_rows, MAX_DIM) | dim_bad(r_b_cols, MAX_DIM) |
                                (r_a_rows != r_b_rows) | (r_a_cols != r_b_cols);
            OP_TRANSPOSE,
            OP_SCALAR: w_req_bad = dim_bad(r_a_rows, MAX_DIM) | dim_bad(r_a_cols, MAX_DIM);
            OP_MUL: w_req_bad = dim_bad(r_a_rows, MAX_DIM) | dim_bad(r_a_cols, MAX_DIM) |
                                dim_bad(r_b_rows, MAX_DIM) | dim_bad(r_b_cols, MAX_DIM) |
                                (r_a_cols != r_b_rows);
            default: w_req_bad = 1'b1;
        endcase
    end

    // Element ops use a single-step k loop so every iteration is "last k".
    assign w_lim_j = (r_op == OP_MUL) ? r_b_cols : r_a_cols;
    assign w_lim_k = (r_op == OP_MUL) ? r_a_cols : DIM_W'(1);

    mat_index_counter u_index (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state != ST_RUN),
        .i_en       ((r_state == ST_RUN) && !i_abort),
        .i_lim_i    (r_a_rows),
        .i_lim_j    (w_lim_j),
        .i_lim_k    (w_lim_k),
        .o_i        (w_i),
        .o_j        (w_j),
        .o_k        (w_k),
        .o_last_k   (w_last_k),
        .o_last_all (w_last_all)
    );

    // ------------------------------------------------------------------
    // Address generation from the live loop indices
    // ------------------------------------------------------------------
    always_comb begin
        w_a_flat   = elem_addr(w_i, w_j, r_a_cols);
        w_b_flat   = w_a_flat;
        w_res_flat = w_a_flat;
        w_res_rows = r_a_rows;
        w_res_cols = r_a_cols;
        case (r_op)
            OP_MUL: begin
                w_a_flat   = elem_addr(w_i, w_k, r_a_cols);
                w_b_flat   = elem_addr(w_k, w_j, r_b_cols);
                w_res_flat = elem_addr(w_i, w_j, r_b_cols);
                w_res_cols = r_b_cols;
            end
            OP_TRANSPOSE: begin
                w_res_flat = elem_addr(w_j, w_i, r_a_rows);
                w_res_rows = r_a_cols;
                w_res_cols = r_a_rows;
            end
            default: ;
        endcase
    end

    assign o_a_addr = (r_state == ST_RUN) ? ADDR_W'(w_a_flat) : '0;
    assign o_b_addr = (r_state == ST_RUN) ? ADDR_W'(w_b_flat) : '0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_start     <= 1'b0;
            r_op        <= '0;
            r_a_rows    <= '0;
            r_a_cols    <= '0;
            r_b_rows    <= '0;
            r_b_cols    <= '0;
            r_scalar    <= '0;
            r_drain_cnt <= 1'b0;
            o_busy      <= 1'b0;
            o_calc_done <= 1'b0;
            o_error_out <= 1'b0;
            o_res_rows  <= '0;
            o_res_cols  <= '0;
        end else begin
            r_start     <= i_start;
            o_calc_done <= 1'b0;
            o_error_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Abort has no meaning here; a start edge always wins.
                    if (w_start_edge) begin
                        r_op     <= i_op_type;
                        r_a_rows <= i_a_rows;
                        r_a_cols <= i_a_cols;
                        r_b_rows <= i_b_rows;
                        r_b_cols <= i_b_cols;
                        r_scalar <= i_scalar;
                        r_state  <= ST_CHECK;
                        o_busy   <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else if (w_req_bad) begin
                        r_state     <= ST_ERR;
                        o_error_out <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else if (w_last_all) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else if (r_drain_cnt) begin
                        r_state     <= ST_DONE;
                        o_calc_done <= 1'b1;
                        o_res_rows  <= w_res_rows;
                        o_res_cols  <= w_res_cols;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath. Plain vectors are used for two's complement values: the
    // low ACC_W bits of add/multiply are identical for signed and
    // unsigned interpretation, which gives the required modulo wrap.
    // ------------------------------------------------------------------
    assign w_a_ext = {{(ACC_W-DATA_W){i_a_data[DATA_W-1]}}, i_a_data};
    assign w_b_ext = {{(ACC_W-DATA_W){i_b_data[DATA_W-1]}}, i_b_data};
    assign w_s_ext = {{(ACC_W-DATA_W){r_scalar[DATA_W-1]}}, r_scalar};

    always_comb begin
        w_elem = w_a_ext;
        case (r_op)
            OP_ADD:    w_elem = w_a_ext + w_b_ext;
            OP_SCALAR: w_elem = w_a_ext * w_s_ext;
            OP_MUL:    w_elem = (r_p1_first ? '0 : r_acc) + w_a_ext * w_b_ext;
            default:   w_elem = w_a_ext;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_addr  <= '0;
            r_acc      <= '0;
            o_res_we   <= 1'b0;
            o_res_addr <= '0;
            o_res_data <= '0;
        end else begin
            r_p1_valid <= (r_state == ST_RUN) && !w_kill;
            r_p1_first <= (w_k == '0);
            r_p1_last  <= w_last_k;
            r_p1_addr  <= ADDR_W'(w_res_flat);
            // An abort also discards whatever is still in flight.
            o_res_we   <= r_p1_valid && r_p1_last && !w_kill;
            if (r_p1_valid) begin
                r_acc <= w_elem;
                if (r_p1_last) begin
                    o_res_addr <= r_p1_addr;
                    o_res_data <= w_elem;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_op_sequencer
// Description : Self-checking bench for matrix_op_sequencer. A vector table
//               of operations with hand-computed results and cycle numbers,
//               plus directed sequences for abort, held start and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_matrix_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  op = '0;
    logic [2:0]  ar = '0, ac = '0, br = '0, bc = '0;
    logic [7:0]  scalar = '0;
    logic [4:0]  a_addr, b_addr, res_addr;
    logic [7:0]  a_data = '0, b_data = '0;
    logic        res_we;
    logic [19:0] res_data;
    logic [2:0]  res_rows, res_cols;
    logic        busy, calc_done, error_out;

    logic [7:0]  a_mem [32];
    logic [7:0]  b_mem [32];
    logic [19:0] res_mem [32];

    int cyc = 0, c0 = 0;
    int n_chk = 0, n_fail = 0;
    int nwr, ndone, nerr, done_c, err_c, fall_c, first_w, last_w, gap_bad;

    typedef struct {
        string      name;
        logic [3:0] op;
        int ar, ac, br, bc, scal;
        int abase, astep, bbase, bstep;
        bit err;
        int nwr, kd, rr, rc, done;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];
    int   exp_tab [NV][6];

    matrix_op_sequencer #(.DATA_W(8), .ACC_W(20), .MAX_DIM(5), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_op_type(op),
        .i_a_rows(ar), .i_a_cols(ac), .i_b_rows(br), .i_b_cols(bc), .i_scalar(scalar),
        .o_a_addr(a_addr), .o_b_addr(b_addr), .i_a_data(a_data), .i_b_data(b_data),
        .o_res_we(res_we), .o_res_addr(res_addr), .o_res_data(res_data),
        .o_res_rows(res_rows), .o_res_cols(res_cols), .o_busy(busy),
        .o_calc_done(calc_done), .o_error_out(error_out)
    );

    always #5 clk = ~clk;

    // Synchronous operand storage: data one cycle after address.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string nm, input logic [3:0] o,
                                input int r1, c1, r2, c2, s, ab, as, bb, bs,
                                input bit e, input int n, k, rr, rc, d);
        vec_t t;
        t.name = nm; t.op = o; t.ar = r1; t.ac = c1; t.br = r2; t.bc = c2; t.scal = s;
        t.abase = ab; t.astep = as; t.bbase = bb; t.bstep = bs; t.err = e;
        t.nwr = n; t.kd = k; t.rr = rr; t.rc = rc; t.done = d;
        return t;
    endfunction

    task automatic fill(input int ab, as, bb, bs);
        for (int k = 0; k < 32; k++) begin
            a_mem[k]   = 8'(ab + as * k);
            b_mem[k]   = 8'(bb + bs * k);
            res_mem[k] = 20'hAAAAA;
        end
    endtask

    // Called #1 after a rising edge; that cycle becomes cycle 0.
    task automatic launch(input logic [3:0] o, input int r1, c1, r2, c2, s, input bit ab);
        op = o; ar = 3'(r1); ac = 3'(c1); br = 3'(r2); bc = 3'(c2); scalar = 8'(s);
        start = 1'b1;
        abort = ab;
        c0 = cyc;
        if (ab) begin
            @(posedge clk);
            #1 abort = 1'b0;
        end
    endtask

    task automatic watch(input int kd);
        int  rel;
        bit  seen_busy;
        seen_busy = 0;
        nwr = 0; ndone = 0; nerr = 0; done_c = -1; err_c = -1; fall_c = -1;
        first_w = -1; last_w = -1; gap_bad = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rel = cyc - c0;
            if (res_we) begin
                res_mem[res_addr] = res_data;
                if (first_w < 0) first_w = rel;
                else if (rel - last_w != kd) gap_bad++;
                last_w = rel;
                nwr++;
            end
            if (calc_done) begin ndone++; done_c = rel; end
            if (error_out) begin nerr++;  err_c  = rel; end
            if (busy) seen_busy = 1;
            else if (seen_busy) begin
                fall_c = rel;
                break;
            end
        end
    endtask

    task automatic run_vec(input int v, input bit ab);
        vec_t t;
        t = vt[v];
        fill(t.abase, t.astep, t.bbase, t.bstep);
        launch(t.op, t.ar, t.ac, t.br, t.bc, t.scal, ab);
        watch(t.kd);
        if (t.err) begin
            chk({t.name, ".err_cycle"}, err_c, 2);
            chk({t.name, ".n_err"},     nerr, 1);
            chk({t.name, ".n_writes"},  nwr, 0);
            chk({t.name, ".n_done"},    ndone, 0);
            chk({t.name, ".busy_fall"}, fall_c, 3);
        end else begin
            chk({t.name, ".n_err"},       nerr, 0);
            chk({t.name, ".done_cycle"},  done_c, t.done);
            chk({t.name, ".n_done"},      ndone, 1);
            chk({t.name, ".busy_fall"},   fall_c, t.done + 1);
            chk({t.name, ".n_writes"},    nwr, t.nwr);
            chk({t.name, ".first_write"}, first_w, 3 + t.kd);
            chk({t.name, ".last_write"},  last_w, t.done - 1);
            chk({t.name, ".write_gaps"},  gap_bad, 0);
            chk({t.name, ".res_rows"},    res_rows, t.rr);
            chk({t.name, ".res_cols"},    res_cols, t.rc);
            for (int k = 0; k < 6 && k < t.nwr; k++)
                chk($sformatf("%s.res[%0d]", t.name, k),
                    longint'($signed(res_mem[k])), exp_tab[v][k]);
        end
        start = 1'b0;
        idle(3);
    endtask

    initial begin
        int post_we, post_done, post_err;

        //                name            op  ar ac br bc scal abase astep bbase bstep err nwr kd rr rc done
        vt[0]  = mk("add2x3",       4'd1, 2, 3, 2, 3, 0,    1,    1,   10,   10,  0,  6, 1, 2, 3, 10);
        vt[1]  = mk("tr2x3",        4'd2, 2, 3, 0, 0, 0,    1,    1,    0,    0,  0,  6, 1, 3, 2, 10);
        vt[2]  = mk("scal2x2",      4'd3, 2, 2, 0, 0, -3,   1,    1,    0,    0,  0,  4, 1, 2, 2,  8);
        vt[3]  = mk("mul2x2",       4'd4, 2, 2, 2, 2, 0,    1,    1,    5,    1,  0,  4, 2, 2, 2, 12);
        vt[4]  = mk("mul5x5",       4'd4, 5, 5, 5, 5, 0, -128,    0, -128,    0,  0, 25, 5, 5, 5, 129);
        vt[5]  = mk("mul1x1",       4'd4, 1, 1, 1, 1, 0,    3,    0,   -4,    0,  0,  1, 1, 1, 1,  5);
        vt[6]  = mk("tr5x1",        4'd2, 5, 1, 0, 0, 0,    1,    1,    0,    0,  0,  5, 1, 1, 5,  9);
        vt[7]  = mk("add_mismatch", 4'd1, 2, 3, 3, 2, 0,    1,    1,    1,    1,  1,  0, 1, 0, 0, -1);
        vt[8]  = mk("bad_op7",      4'd7, 2, 2, 2, 2, 0,    1,    1,    1,    1,  1,  0, 1, 0, 0, -1);
        vt[9]  = mk("rows6",        4'd3, 6, 2, 0, 0, 2,    1,    1,    1,    1,  1,  0, 1, 0, 0, -1);
        vt[10] = mk("add_zero",     4'd1, 2, 0, 2, 0, 0,    1,    1,    1,    1,  1,  0, 1, 0, 0, -1);

        exp_tab[0]  = '{11, 22, 33, 44, 55, 66};
        exp_tab[1]  = '{1, 4, 2, 5, 3, 6};
        exp_tab[2]  = '{-3, -6, -9, -12, 0, 0};
        exp_tab[3]  = '{19, 22, 43, 50, 0, 0};
        exp_tab[4]  = '{81920, 81920, 81920, 81920, 81920, 81920};
        exp_tab[5]  = '{-12, 0, 0, 0, 0, 0};
        exp_tab[6]  = '{1, 2, 3, 4, 5, 0};
        for (int v = 7; v < NV; v++) exp_tab[v] = '{0, 0, 0, 0, 0, 0};

        // Reset state
        #12;
        chk("reset.busy",      busy, 0);
        chk("reset.res_we",    res_we, 0);
        chk("reset.calc_done", calc_done, 0);
        chk("reset.error_out", error_out, 0);
        chk("reset.res_data",  res_data, 0);
        chk("reset.res_rows",  res_rows, 0);
        chk("reset.a_addr",    a_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        for (int v = 0; v < NV; v++) run_vec(v, 1'b0);

        // Abort mid-RUN of a 3x3 MUL
        fill(1, 1, 1, 1);
        launch(4'd4, 3, 3, 3, 3, 0, 1'b0);
        idle(10);
        chk("abort.busy_before", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        post_we = 0; post_done = 0; post_err = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) chk("abort.busy_after", busy, 0);
            if (res_we)    post_we++;
            if (calc_done) post_done++;
            if (error_out) post_err++;
        end
        chk("abort.writes_after", post_we, 0);
        chk("abort.n_done",       post_done, 0);
        chk("abort.n_err",        post_err, 0);
        start = 1'b0;
        idle(3);
        run_vec(3, 1'b0);

        // Start and abort together in IDLE: start wins
        run_vec(0, 1'b1);

        // Start held high for 50 cycles: exactly one operation
        fill(1, 1, 10, 10);
        launch(4'd1, 2, 3, 2, 3, 0, 1'b0);
        post_we = 0; post_done = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (res_we)    post_we++;
            if (calc_done) post_done++;
        end
        chk("held.n_done",   post_done, 1);
        chk("held.n_writes", post_we, 6);
        start = 1'b0;
        idle(3);

        // Reset asserted mid-RUN while a write is on the bus
        fill(1, 1, 5, 1);
        launch(4'd4, 2, 2, 2, 2, 0, 1'b0);
        idle(7);
        chk("rstmid.we_before", res_we, 1);
        rst = 1'b1;
        #1;
        chk("rstmid.res_we",   res_we, 0);
        chk("rstmid.busy",     busy, 0);
        chk("rstmid.res_data", res_data, 0);
        chk("rstmid.res_addr", res_addr, 0);
        chk("rstmid.a_addr",   a_addr, 0);
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        run_vec(5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
